// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed multiply/divide unit. A multiply produces a
//               64-bit product on hi:lo. A divide produces the quotient on lo
//               and the remainder on hi. A normal operation takes 33 cycles
//               from the start edge to the done pulse. A divide by zero
//               completes on the next edge and leaves hi/lo unchanged.
// Ports       : clk        rising-edge clock
//               reset      asynchronous active-low reset
//               start_mult request a signed multiply A*B (sampled in IDLE)
//               start_div  request a signed divide A/B (sampled in IDLE)
//               A, B       operands, latched at the start edge
//               hi, lo     registered results
//               busy       high while an operation is in flight
//               done       one-cycle completion pulse
//               div_zero   one-cycle pulse with done when the divisor was 0
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  // acc holds the product upper half (multiply) or partial remainder (divide);
  // low holds the multiplier/product lower half or dividend/quotient bits.
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic               neg_q, neg_d;      // result sign: sign(A)^sign(B)
  logic               sa_q, sa_d;        // sign of A, for the remainder
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;        // divide-by-zero pending in FIX
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    acc_d      = acc_q;
    low_d      = low_q;
    neg_d      = neg_q;
    sa_d       = sa_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {acc,low} pair right by one.
    mul_sum   = {1'b0, acc_q} + {1'b0, (low_q[0] ? a_mag_q : '0)};
    // Restoring-division step on a WIDTH+1 bit partial remainder.
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    prod      = {acc_q, low_q};
    prod_neg  = -prod;

    unique case (state_q)
      S_IDLE: begin
        if (start_mult || start_div) begin
          // Magnitude of 0x80000000 wraps to itself, which is 2^31 unsigned.
          a_mag_d  = A[WIDTH-1] ? -A : A;
          b_mag_d  = B[WIDTH-1] ? -B : B;
          neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
          sa_d     = A[WIDTH-1];
          cnt_d    = '0;
          acc_d    = '0;
          busy_d   = 1'b1;
          dz_d     = 1'b0;
          if (start_mult) begin
            is_div_d = 1'b0;
            low_d    = B[WIDTH-1] ? -B : B;
            state_d  = S_MULT;
          end else begin
            is_div_d = 1'b1;
            low_d    = A[WIDTH-1] ? -A : A;
            if (B == '0) begin
              dz_d    = 1'b1;
              state_d = S_FIX;
            end else begin
              state_d = S_DIV;
            end
          end
        end
      end
      S_MULT: begin
        acc_d = mul_sum[WIDTH:1];
        low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_DIV: begin
        // Negative difference means the divisor did not fit: keep the shift.
        acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        low_d = {low_q[WIDTH-2:0], ~div_diff[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_q ? -low_q : low_q;
          hi_d = sa_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      acc_q      <= '0;
      low_q      <= '0;
      neg_q      <= 1'b0;
      sa_q       <= 1'b0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      acc_q      <= acc_d;
      low_q      <= low_d;
      neg_q      <= neg_d;
      sa_q       <= sa_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks;
  int failures;
  int lat;
  int done_cyc;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .A          (A),
    .B          (B),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one start at edge E0, then counts edges until done (bounded).
  // Returns #1 after the edge on which done rose.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    A          = a;
    B          = b;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    A          = 32'hDEAD_BEEF;
    B          = 32'h1234_5678;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    A          = '0;
    B          = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {28'd0, busy, done, div_zero, 1'b0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // T1: 3 * -5 = -15
    run_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFB, lat);
    chk("t1_latency", 64'(lat), 64'd33);
    chk("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("t1_flags", {62'd0, busy, div_zero}, 64'd0);
    @(posedge clk);
    #1;
    chk("t1_done_one_cycle", {63'd0, done}, 64'd0);

    // T2: max positive squared, then most-negative squared
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
    chk("t2a_hilo", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat);
    chk("t2b_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    // T3: -7/2 -> q=-3 r=-1 ; 7/-2 -> q=-3 r=1
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("t3a_latency", 64'(lat), 64'd33);
    chk("t3a_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    chk("t3b_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    // T4: divide by zero, hi/lo must keep the T3 result
    run_op(1'b0, 1'b1, 32'd10, 32'd0, lat);
    chk("t4_latency", 64'(lat), 64'd1);
    chk("t4_div_zero", {62'd0, done, div_zero}, 64'd3);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    chk("t4_hilo_kept", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    @(posedge clk);
    #1;
    chk("t4_pulse_end", {62'd0, done, div_zero}, 64'd0);

    // T5: -2^31 / -1 wraps without a flag
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("t5_latency", 64'(lat), 64'd33);
    chk("t5_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("t5_no_flag", {63'd0, div_zero}, 64'd0);

    // Ignored starts while busy, run to completion: 6*7 must still give 42
    @(negedge clk);
    start_mult = 1'b1;
    A = 32'd6;
    B = 32'd7;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_div  = (c == 5 || c == 8);
      start_mult = (c == 8);
      A = 32'd100;
      B = 32'd0;
      @(posedge clk);
      #1;
      if (done && done_cyc == 0) begin
        done_cyc = c;
        break;
      end
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
    chk("busy_start_latency", 64'(done_cyc), 64'd33);
    chk("busy_start_hilo", {hi, lo}, 64'd42);
    chk("busy_start_no_dz", {63'd0, div_zero}, 64'd0);

    // T6: starts ignored, then async reset mid-operation
    @(negedge clk);
    start_mult = 1'b1;
    A = 32'd6;
    B = 32'd7;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_div  = (c == 5 || c == 8);
      start_mult = (c == 8);
      @(posedge clk);
      #1;
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
    chk("t6_busy_before_reset", {63'd0, busy}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_reset_flags", {62'd0, busy, done}, 64'd0);
    chk("t6_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Both starts together: multiply wins, -4*6 = -24
    run_op(1'b1, 1'b1, 32'hFFFF_FFFC, 32'd6, lat);
    chk("t6_both_latency", 64'(lat), 64'd33);
    chk("t6_both_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE8);
    chk("t6_both_no_dz", {63'd0, div_zero}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
